div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Sequential restoring integer divider for the RV32-APX datapath; it is the inverse-operation counterpart of the Booth multiplier unit.
- Takes dividend and divisor on the same 32-bit operand buses, operates on the low OP_W bits (approximate-width mode), and returns quotient and remainder.
- Produces one quotient bit per cycle, with a start/busy/done handshake to the execute stage.
- Follows RISC-V DIV/DIVU/REM/REMU corner-case semantics at width OP_W.

Parameters:
- OP_W, 16, operand width actually divided; low OP_W bits of each operand are used, upper bits ignored; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- start  input  1  request a division; sampled only in IDLE
- is_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start
- read_a  input  32  dividend; bits [OP_W-1:0] used
- read_x  input  32  divisor; bits [OP_W-1:0] used
- busy  output  1  high from the edge accepting start until the edge before done
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  32  quotient, extended to 32 bits
- remainder  output  32  remainder, extended to 32 bits

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0; internal counter and registers cleared.
  - Reset has priority over everything and aborts any operation in flight with no done pulse.
- Operand capture (edge with state==IDLE and start==1):
  - Latch a=read_a[OP_W-1:0], x=read_x[OP_W-1:0], and is_signed.
  - Signed mode: record sign_q=a[MSB]^x[MSB] and sign_r=a[MSB]; divide magnitudes.
  - Unsigned mode: divide raw values.
- State machine, one transition per edge:
  - IDLE -> CALC on start (normal path). Sets busy=1, counter=OP_W.
  - IDLE -> DONE on start when the fast path applies.
  - CALC: shift the partial remainder left 1, bring in the next dividend bit (MSB first), trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0. Decrement counter. Go to FIX after OP_W CALC cycles.
  - FIX: negate the quotient if sign_q, negate the remainder if sign_r (signed mode only). Drive quotient/remainder: sign-extended to 32 in signed mode, zero-extended in unsigned mode. Set done=1, busy=0. -> IDLE.
  - DONE (fast path): drive the fast-path results, done=1, busy=0. -> IDLE.
- Latency:
  - Normal path: done is high in the cycle after the (OP_W+1)-th edge following the capture edge, i.e. OP_W+2 edges counting the capture edge.
  - Fast path: done is high after 2 edges (capture edge, then DONE edge).
- done is exactly one cycle; quotient/remainder hold their value until the next operation's done or reset.
- start while busy is ignored and never queued. start in the same cycle done is high is accepted (state is IDLE then only if it returned; start is sampled only in IDLE).
- Fast path conditions:
  - Divide by zero (x==0): quotient=32'hFFFFFFFF (both modes); remainder = a extended per mode.
  - Signed overflow (is_signed, a==1 followed by OP_W-1 zeros, i.e. most negative, and x==all ones, i.e. -1): quotient = a sign-extended; remainder=0.
- Arithmetic:
  - Internal datapath is OP_W+1 bits for the trial subtraction.
  - Remainder sign follows the dividend and |remainder| < |divisor| always.
  - Quotient truncates toward zero.
- Upper operand bits [31:OP_W] never affect results.

Test Plan (OP_W=16):
- Unsigned 100/7: start, is_signed=0, read_a=32'h0000_0064, read_x=32'h0000_0007 -> quotient=32'h0000000E, remainder=32'h00000002. done exactly 18 edges after the capture edge (inclusive); busy high in between.
- Signed -100/7: read_a=32'h0000FF9C, read_x=32'h00000007, is_signed=1 -> quotient=32'hFFFFFFF2, remainder=32'hFFFFFFFE. Also 100/-7 -> quotient=32'hFFFFFFF2, remainder=32'h00000002.
- Divide by zero and overflow:
  - 1234/0 unsigned -> quotient=32'hFFFFFFFF, remainder=32'h000004D2, done 2 edges after capture.
  - Signed 16'h8000/16'hFFFF -> quotient=32'hFFFF8000, remainder=0, fast latency.
- Upper-bit masking and unsigned full range:
  - read_a=32'hABCD0064, read_x=32'h12340007 -> same result as 100/7.
  - Unsigned 16'hFFFF/16'h0003 -> quotient=32'h00005555, remainder=0.
- Handshake:
  - Pulse start again 5 cycles into an operation with different operands -> ignored; the first result is delivered unchanged.
  - Start asserted continuously -> back-to-back operations; each done is a single cycle.
- Reset mid-operation: drive reset=0 for 1 edge at CALC cycle 8 -> busy=0, done never pulses, quotient=remainder=0. A new 100/7 afterwards completes correctly.

Source files
------------

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per cycle over the low OP_W operand bits,
// with RISC-V DIV/DIVU/REM/REMU corner cases (divide by zero, signed overflow) on a 2-cycle fast path.
module div_seq #(
    parameter int OP_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] read_a,
    input  logic [31:0] read_x,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CNT_W = $clog2(OP_W + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [OP_W-1:0]  MOST_NEG = {1'b1, {(OP_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OP_W);

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0] div_q, div_d;
    logic [OP_W-1:0] rem_q, rem_d;
    logic [OP_W-1:0] xmag_q, xmag_d;
    logic            signed_q, signed_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [31:0]     quo_out_q, quo_out_d;
    logic [31:0]     rem_out_q, rem_out_d;

    logic [OP_W-1:0] a_in, x_in, a_mag, x_mag, q_val, r_val;
    logic [OP_W:0]   partial, trial;
    logic            fast;

    // Upper operand bits are deliberately ignored by the datapath.
    logic unused_hi;
    assign unused_hi = ^{read_a, read_x};

    function automatic logic [31:0] extend(input logic [OP_W-1:0] v, input logic sx);
        logic [31:0] e;
        e = {32{sx & v[OP_W-1]}};
        e[OP_W-1:0] = v;
        return e;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        rem_d     = rem_q;
        xmag_d    = xmag_q;
        signed_d  = signed_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;

        a_in  = read_a[OP_W-1:0];
        x_in  = read_x[OP_W-1:0];
        a_mag = (is_signed && a_in[OP_W-1]) ? -a_in : a_in;
        x_mag = (is_signed && x_in[OP_W-1]) ? -x_in : x_in;
        fast  = (x_in == '0) || (is_signed && a_in == MOST_NEG && x_in == '1);

        // div_q doubles as the dividend shift register and the quotient accumulator.
        partial = {rem_q, div_q[OP_W-1]};
        trial   = partial - {1'b0, xmag_q};
        q_val   = neg_quo_q ? -div_q : div_q;
        r_val   = neg_rem_q ? -rem_q : rem_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    signed_d  = is_signed;
                    neg_quo_d = is_signed & (a_in[OP_W-1] ^ x_in[OP_W-1]);
                    neg_rem_d = is_signed & a_in[OP_W-1];
                    xmag_d    = x_mag;
                    rem_d     = '0;
                    cnt_d     = CNT_INIT;
                    busy_d    = 1'b1;
                    // The fast path keeps the raw dividend; both corner results derive from it.
                    div_d     = fast ? a_in : a_mag;
                    state_d   = fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                rem_d   = trial[OP_W] ? partial[OP_W-1:0] : trial[OP_W-1:0];
                div_d   = {div_q[OP_W-2:0], ~trial[OP_W]};
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quo_out_d = extend(q_val, signed_q);
                rem_out_d = extend(r_val, signed_q);
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            S_DONE: begin
                if (xmag_q == '0) begin
                    quo_out_d = '1;
                    rem_out_d = extend(div_q, signed_q);
                end else begin
                    quo_out_d = extend(div_q, 1'b1);
                    rem_out_d = '0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            xmag_q    <= '0;
            signed_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            xmag_q    <= xmag_d;
            signed_q  <= signed_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_out_q;
    assign remainder = rem_out_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized bench for div_seq at OP_W=16, checked against an integer-arithmetic model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] read_a = '0;
    logic [31:0] read_x = '0;
    logic        busy, done;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_seq #(.OP_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .read_a    (read_a),
        .read_x    (read_x),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V division semantics on 16-bit operands, using plain integer arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] x, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
        logic [15:0] a16, x16;
        int av, xv;
        a16 = a[15:0];
        x16 = x[15:0];
        av  = s ? int'($signed(a16)) : int'(a16);
        xv  = s ? int'($signed(x16)) : int'(x16);
        if (xv == 0) begin
            q = 32'hFFFF_FFFF; r = av; lat = 2;
        end else if (s && av == -32768 && xv == -1) begin
            q = av; r = 0; lat = 2;
        end else begin
            q = av / xv; r = av % xv; lat = 18;
        end
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] x, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input int elat, input bit poke);
        int edges;
        bit busy_ok;
        @(negedge clk);
        read_a = a; read_x = x; is_signed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && edges < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (poke && edges == 5) begin
                start = 1'b1; read_a = 32'h0000_0FFF; read_x = 32'h0000_0003; is_signed = ~s;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, " latency"}, edges, elat);
        chk({tag, " busy_during"}, busy_ok, 1);
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        $display("op %s a=%h x=%h s=%0d -> q=%h r=%h lat=%0d", tag, a, x, s, quotient, remainder, edges);
        @(posedge clk); #1;
        chk({tag, " done_single"}, done, 0);
    endtask

    initial begin
        int edges;
        bit saw_done;
        logic [31:0] a, x, eq, er;
        logic s;
        int lat, k;

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        reset = 1'b1;

        run_op("u100/7", 32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0000_000E, 32'h0000_0002, 18, 0);
        run_op("s-100/7", 32'h0000_FF9C, 32'h0000_0007, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 18, 0);
        run_op("s100/-7", 32'h0000_0064, 32'h0000_FFF9, 1'b1, 32'hFFFF_FFF2, 32'h0000_0002, 18, 0);
        run_op("u1234/0", 32'h0000_04D2, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h0000_04D2, 2, 0);
        run_op("s-1234/0", 32'h0000_FB2E, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FB2E, 2, 0);
        run_op("s_ovf", 32'h0000_8000, 32'h0000_FFFF, 1'b1, 32'hFFFF_8000, 32'h0000_0000, 2, 0);
        run_op("u_mask", 32'hABCD_0064, 32'h1234_0007, 1'b0, 32'h0000_000E, 32'h0000_0002, 18, 0);
        run_op("uFFFF/3", 32'h0000_FFFF, 32'h0000_0003, 1'b0, 32'h0000_5555, 32'h0000_0000, 18, 0);
        run_op("s-32768/1", 32'h0000_8000, 32'h0000_0001, 1'b1, 32'hFFFF_8000, 32'h0000_0000, 18, 0);
        run_op("poke_ignored", 32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0000_000E, 32'h0000_0002, 18, 1);

        // Continuous start: second operation is captured the cycle done is high.
        @(negedge clk);
        read_a = 32'h0000_0064; read_x = 32'h0000_0007; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        read_a = 32'h0000_FFFF; read_x = 32'h0000_0003;
        edges = 1;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
        chk("b2b first latency", edges, 18);
        chk("b2b first quotient", quotient, 32'h0000_000E);
        chk("b2b first remainder", remainder, 32'h0000_0002);
        $display("op b2b_first q=%h r=%h lat=%0d", quotient, remainder, edges);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b done_single", done, 0);
        chk("b2b second busy", busy, 1);
        edges = 1;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
        chk("b2b second latency", edges, 18);
        chk("b2b second quotient", quotient, 32'h0000_5555);
        chk("b2b second remainder", remainder, 32'h0000_0000);
        $display("op b2b_second q=%h r=%h lat=%0d", quotient, remainder, edges);
        @(posedge clk); #1;
        chk("b2b second done_single", done, 0);

        // Reset during CALC aborts with no done pulse and clears the results.
        @(negedge clk);
        read_a = 32'h0000_0064; read_x = 32'h0000_0007; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        while (edges < 8) begin
            @(posedge clk); #1; edges++;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst quotient", quotient, 0);
        chk("midrst remainder", remainder, 0);
        saw_done = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("midrst no_done", saw_done, 0);
        $display("op midrst busy=%0d q=%h r=%h", busy, quotient, remainder);
        run_op("after_rst", 32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0000_000E, 32'h0000_0002, 18, 0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            x = $urandom;
            s = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 7);
            if (k == 0) x[15:0] = 16'h0000;
            if (k == 1) begin
                s = 1'b1; a[15:0] = 16'h8000; x[15:0] = 16'hFFFF;
            end
            if (k == 2) x[15:0] = 16'($urandom_range(1, 15));
            model(a, x, s, eq, er, lat);
            run_op($sformatf("rand%0d", i), a, x, s, eq, er, lat, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
